hal_timer_regs: RTL and testbench
=================================

// Module: hal_timer_regs
// PURPOSE
//  Interval-timer register block on the exported hal_timer slave conduit of the hal_timer system.
//  It is the target of the 3-bit address / 16-bit data bus driven by the Nios side: it decodes
//  register accesses, runs a prescaled 32-bit down counter, and raises a sticky timeout flag,
//  a level IRQ and a one-cycle timeout pulse for the rest of the FPGA fabric.
// PARAMETERS
//  RESET_PERIOD  32'd49_999  counter reload value after reset (1 ms at 50 MHz with prescale 0)
//  RESET_PRESC   16'd0       prescale reload value after reset; tick every PRESC+1 clocks
// PORTS
//  clk_clk               in   1   system clock; all logic on its rising edge
//  reset_reset           in   1   asynchronous, active-high reset
//  hal_timer_address     in   3   register index (16-bit word registers)
//  hal_timer_writedata   in   16  write data
//  hal_timer_readdata    out  16  read data, registered
//  hal_timer_chipselect  in   1   access qualifier
//  hal_timer_write_n     in   1   0 = write, 1 = read (valid only with chipselect=1)
//  timer_irq             out  1   level: STATUS.TO & CONTROL.ITO
//  timer_pulse           out  1   one-clock pulse on every timeout event
// BEHAVIOUR
//  Register map (addr: name, bits):
//   0 STATUS  [0]=TO sticky timeout, any write clears; [1]=RUN read-only
//   1 CONTROL [0]=ITO irq enable; [1]=CONT auto-reload; [2]=START strobe; [3]=STOP strobe (2,3 read 0)
//   2 PERIODL, 3 PERIODH  reload value [15:0]/[31:16]
//   4 SNAPL, 5 SNAPH      snapshot [15:0]/[31:16]; a write to either captures counter into snapshot
//   6 PRESC   prescale reload value; 7 reserved: writes ignored, reads 0
//  Reset: readdata=0, timer_irq=0, timer_pulse=0, TO=0, RUN=0, ITO=0, CONT=0,
//   period=RESET_PERIOD, counter=RESET_PERIOD, presc=RESET_PRESC, presc_cnt=RESET_PRESC, snapshot=0.
//  Write: on the edge where chipselect=1 and write_n=0; takes effect for the next cycle.
//  Read: on the edge where chipselect=1 and write_n=1, readdata <= selected register;
//   1-cycle latency; readdata holds its value otherwise; reads have no side effects.
//  States: IDLE (RUN=0) and COUNT (RUN=1).
//   IDLE -> COUNT on a CONTROL write with START=1 and STOP=0: counter<=period, presc_cnt<=presc.
//   COUNT -> IDLE on a CONTROL write with STOP=1; counter holds its value.
//   A START while in COUNT restarts: counter<=period, presc_cnt<=presc.
//   A write to PERIODL/H or PRESC forces IDLE and loads counter<=new period (presc_cnt<=new presc).
//  Tick: in COUNT, presc_cnt decrements each clock; at presc_cnt==0 a tick occurs and presc_cnt<=presc.
//  On tick: if counter!=0, counter<=counter-1. If counter==0 this is a timeout:
//   TO<=1; timer_pulse=1 for exactly that next cycle.
//   CONT=1: counter<=period, stay in COUNT. CONT=0: go to IDLE, counter<=period.
//  Period 0 with CONT=1 gives a timeout every tick. No wrap below 0 ever occurs.
//  Simultaneous events:
//   - STATUS write in the timeout cycle: TO=1 (set wins).
//   - START and STOP in the same write: STOP wins.
//   - Snapshot write in a tick cycle: captures the pre-decrement value.
//  timer_irq is combinational from registered TO and ITO.
//  Reset asserted mid-count: all state returns to reset values immediately; no pulse is emitted.
// TESTING
//  1 Reset: after reset, read addrs 0..7 -> 0x0000,0x0000,0xC34F,0x0000,0,0,0,0; irq=0, pulse=0.
//  2 One-shot: PERIOD=5, PRESC=0, CONTROL=0x0005 -> pulse 6 clocks after the write edge;
//    STATUS=0x0001; irq=1; RUN=0.
//  3 Continuous + prescale: PERIOD=2, PRESC=3, CONTROL=0x0006 -> pulses every 12 clocks;
//    a STATUS write clears TO, which re-sets at the next pulse.
//  4 Snapshot: PERIOD=0x0001_0000, start, wait 100 clocks, write SNAPL -> SNAPH:SNAPL = 0x0000FF9C +/-1.
//  5 Collisions: a STATUS write aligned with the timeout cycle leaves TO=1;
//    CONTROL=0x000C while running -> RUN=0.
//  6 Async reset pulse mid-count (PERIOD=1000) -> irq, pulse and RUN drop with no clock edge;
//    no pulse follows.

Source files
------------

// File: rtl/hal_timer_regs.sv
// Interval-timer register block: 3-bit/16-bit slave bus, prescaled 32-bit down counter,
// sticky timeout flag, level IRQ and one-cycle timeout pulse.
module hal_timer_regs #(
   parameter logic [31:0] RESET_PERIOD = 32'd49_999,
   parameter logic [15:0] RESET_PRESC  = 16'd0
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [2:0]  hal_timer_address,
   input  logic [15:0] hal_timer_writedata,
   output logic [15:0] hal_timer_readdata,
   input  logic        hal_timer_chipselect,
   input  logic        hal_timer_write_n,
   output logic        timer_irq,
   output logic        timer_pulse
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   state_t      state_r, state_s;
   logic [31:0] counter_r, counter_s;
   logic [15:0] presc_cnt_r, presc_cnt_s;
   logic [31:0] period_r, period_s;
   logic [15:0] presc_r, presc_s;
   logic [31:0] snap_r;
   logic        to_r, ito_r, cont_r, pulse_r;
   logic [15:0] readdata_r, rd_mux_s;
   logic        wr_s, rd_s, timeout_s;
   logic        wr_status_s, wr_ctrl_s, wr_reload_s, wr_snap_s;

   assign wr_s        = hal_timer_chipselect & ~hal_timer_write_n;
   assign rd_s        = hal_timer_chipselect & hal_timer_write_n;
   assign wr_status_s = wr_s && (hal_timer_address == 3'd0);
   assign wr_ctrl_s   = wr_s && (hal_timer_address == 3'd1);
   assign wr_reload_s = wr_s && ((hal_timer_address == 3'd2) || (hal_timer_address == 3'd3) ||
                                 (hal_timer_address == 3'd6));
   assign wr_snap_s   = wr_s && ((hal_timer_address == 3'd4) || (hal_timer_address == 3'd5));

   // Reload-value updates from PERIODL/H and PRESC writes
   always_comb begin
      period_s = period_r;
      presc_s  = presc_r;
      if (wr_s) begin
         case (hal_timer_address)
            3'd2:    period_s = {period_r[31:16], hal_timer_writedata};
            3'd3:    period_s = {hal_timer_writedata, period_r[15:0]};
            3'd6:    presc_s  = hal_timer_writedata;
            default: begin
               period_s = period_r;
               presc_s  = presc_r;
            end
         endcase
      end else begin
         period_s = period_r;
         presc_s  = presc_r;
      end
   end

   // Next-state: prescaler/counter tick first, then bus writes override state and counter
   always_comb begin
      state_s     = state_r;
      counter_s   = counter_r;
      presc_cnt_s = presc_cnt_r;
      timeout_s   = 1'b0;
      case (state_r)
         COUNT: begin
            if (presc_cnt_r == 16'd0) begin
               presc_cnt_s = presc_r;
               if (counter_r == 32'd0) begin
                  timeout_s = 1'b1;
                  counter_s = period_r;
                  if (cont_r) begin
                     state_s = COUNT;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  counter_s = counter_r - 32'd1;
               end
            end else begin
               presc_cnt_s = presc_cnt_r - 16'd1;
            end
         end
         IDLE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase

      // STOP takes priority over START; a stop freezes the counter where it is
      if (wr_reload_s) begin
         state_s     = IDLE;
         counter_s   = period_s;
         presc_cnt_s = presc_s;
      end else if (wr_ctrl_s) begin
         if (hal_timer_writedata[3]) begin
            state_s     = IDLE;
            counter_s   = counter_r;
            presc_cnt_s = presc_cnt_r;
         end else if (hal_timer_writedata[2]) begin
            state_s     = COUNT;
            counter_s   = period_r;
            presc_cnt_s = presc_r;
         end else begin
            state_s = state_s;
         end
      end else begin
         state_s = state_s;
      end
   end

   // Read-data selection
   always_comb begin
      rd_mux_s = 16'd0;
      case (hal_timer_address)
         3'd0:    rd_mux_s = {14'd0, (state_r == COUNT), to_r};
         3'd1:    rd_mux_s = {14'd0, cont_r, ito_r};
         3'd2:    rd_mux_s = period_r[15:0];
         3'd3:    rd_mux_s = period_r[31:16];
         3'd4:    rd_mux_s = snap_r[15:0];
         3'd5:    rd_mux_s = snap_r[31:16];
         3'd6:    rd_mux_s = presc_r;
         default: rd_mux_s = 16'd0;
      endcase
   end

   // State, counter and register storage
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_r     <= IDLE;
         counter_r   <= RESET_PERIOD;
         presc_cnt_r <= RESET_PRESC;
         period_r    <= RESET_PERIOD;
         presc_r     <= RESET_PRESC;
         snap_r      <= 32'd0;
         to_r        <= 1'b0;
         ito_r       <= 1'b0;
         cont_r      <= 1'b0;
         pulse_r     <= 1'b0;
         readdata_r  <= 16'd0;
      end else begin
         state_r     <= state_s;
         counter_r   <= counter_s;
         presc_cnt_r <= presc_cnt_s;
         period_r    <= period_s;
         presc_r     <= presc_s;
         pulse_r     <= timeout_s;
         // Timeout set beats a same-cycle STATUS clear
         if (timeout_s) begin
            to_r <= 1'b1;
         end else if (wr_status_s) begin
            to_r <= 1'b0;
         end
         if (wr_ctrl_s) begin
            ito_r  <= hal_timer_writedata[0];
            cont_r <= hal_timer_writedata[1];
         end
         if (wr_snap_s) begin
            snap_r <= counter_r;
         end
         if (rd_s) begin
            readdata_r <= rd_mux_s;
         end
      end
   end

   assign hal_timer_readdata = readdata_r;
   assign timer_pulse        = pulse_r;
   assign timer_irq          = to_r & ito_r;

endmodule

// File: tb/tb_hal_timer_regs.sv
// Directed self-checking bench for hal_timer_regs.
module tb_hal_timer_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  addr = 3'd0;
   logic [15:0] wdata = 16'd0;
   logic [15:0] rdata;
   logic        cs = 1'b0;
   logic        write_n = 1'b1;
   logic        irq, pulse;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_rst [8] = '{16'h0000, 16'h0000, 16'hC34F, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000};

   hal_timer_regs dut (
      .clk_clk              (clk),
      .reset_reset          (rst),
      .hal_timer_address    (addr),
      .hal_timer_writedata  (wdata),
      .hal_timer_readdata   (rdata),
      .hal_timer_chipselect (cs),
      .hal_timer_write_n    (write_n),
      .timer_irq            (irq),
      .timer_pulse          (pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; write_n = 1'b0; addr = a; wdata = d;
      @(posedge clk);
      #1;
      cs = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; write_n = 1'b1; addr = a;
      @(posedge clk);
      #1;
      cs = 1'b0;
      d = rdata;
   endtask

   // Edges until pulse is seen (returns max when it never appears)
   task automatic wait_pulse(input int max, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!pulse && n < max);
   endtask

   initial begin
      logic [15:0] d;
      int n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_pulse", {31'd0, pulse}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd(i[2:0], d);
         check($sformatf("rst_rd%0d", i), {16'd0, d}, {16'd0, exp_rst[i]});
      end
      wr(3'd7, 16'hFFFF);
      rd(3'd7, d);
      check("reserved_rd", {16'd0, d}, 32'd0);
      rd(3'd2, d);
      repeat (4) @(posedge clk);
      #1;
      check("rd_hold", {16'd0, rdata}, 32'h0000C34F);

      // One-shot, period 5, prescale 0
      wr(3'd2, 16'd5);
      wr(3'd3, 16'd0);
      wr(3'd6, 16'd0);
      wr(3'd1, 16'h0005);
      wait_pulse(20, n);
      check("oneshot_lat", n, 32'd6);
      @(posedge clk);
      #1;
      check("oneshot_pulse_width", {31'd0, pulse}, 32'd0);
      rd(3'd0, d);
      check("oneshot_status", {16'd0, d}, 32'h0001);
      check("oneshot_irq", {31'd0, irq}, 32'd1);
      wait_pulse(20, n);
      check("oneshot_no_repeat", n, 32'd20);

      // Continuous with prescale 3, period 2
      wr(3'd2, 16'd2);
      wr(3'd6, 16'd3);
      wr(3'd1, 16'h0006);
      check("cont_irq_masked", {31'd0, irq}, 32'd0);
      wait_pulse(40, n);
      check("cont_first", n, 32'd12);
      wait_pulse(40, n);
      check("cont_period", n, 32'd12);
      wr(3'd0, 16'h0000);
      rd(3'd0, d);
      check("cont_cleared", {16'd0, d}, 32'h0002);
      wait_pulse(40, n);
      check("cont_next", n, 32'd10);
      rd(3'd0, d);
      check("cont_reset_to", {16'd0, d}, 32'h0003);

      // Collisions: STATUS write on the timeout edge, then START+STOP together
      wr(3'd0, 16'h0000);
      wr(3'd1, 16'h0006);
      repeat (11) @(posedge clk);
      wr(3'd0, 16'h0000);
      check("coll_aligned", {31'd0, pulse}, 32'd1);
      rd(3'd0, d);
      check("coll_set_wins", {16'd0, d}, 32'h0003);
      wr(3'd1, 16'h000C);
      rd(3'd0, d);
      check("coll_stop_wins", {16'd0, d}, 32'h0001);
      wait_pulse(30, n);
      check("coll_stopped", n, 32'd30);

      // Snapshot of a running counter
      wr(3'd2, 16'h0000);
      wr(3'd3, 16'h0001);
      wr(3'd6, 16'h0000);
      wr(3'd1, 16'h0004);
      repeat (99) @(posedge clk);
      wr(3'd4, 16'h0000);
      rd(3'd4, d);
      check("snap_lo", {16'd0, d}, 32'h0000FF9D);
      rd(3'd5, d);
      check("snap_hi", {16'd0, d}, 32'h0000);

      // Async reset mid-count
      wr(3'd2, 16'd1000);
      wr(3'd3, 16'd0);
      wr(3'd1, 16'h0005);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_irq", {31'd0, irq}, 32'd0);
      check("async_pulse", {31'd0, pulse}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_pulse(1100, n);
      check("post_rst_no_pulse", n, 32'd1100);
      rd(3'd0, d);
      check("post_rst_status", {16'd0, d}, 32'h0000);
      rd(3'd2, d);
      check("post_rst_period", {16'd0, d}, 32'h0000C34F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
